// File: rtl/wb_write_port.sv
// Writeback write-port driver: MEM/WB register, result select, r0 suppression and
// pipe/debug arbitration; 1-cycle MEM->port latency, stall_req backpressures the pipe.
module wb_write_port #(
  parameter int DSIZE       = 16,
  parameter int ASIZE       = 4,
  parameter int DBG_MAXWAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_wen,
  input  logic [ASIZE-1:0] mem_waddr,
  input  logic [1:0]       mem_wb_sel,
  input  logic [DSIZE-1:0] mem_alu,
  input  logic [DSIZE-1:0] mem_rdata,
  input  logic [DSIZE-1:0] mem_link,
  input  logic             dbg_valid,
  input  logic [ASIZE-1:0] dbg_addr,
  input  logic [DSIZE-1:0] dbg_data,
  output logic             dbg_ready,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [DSIZE-1:0] wdata,
  output logic             stall_req,
  output logic [15:0]      wb_count
);

  localparam int              AGEW    = $clog2(DBG_MAXWAIT + 1);
  localparam logic [AGEW-1:0] AGE_MAX = AGEW'(DBG_MAXWAIT);

  logic             r_wb_valid;
  logic             r_wb_done;
  logic [ASIZE-1:0] r_wb_addr;
  logic [DSIZE-1:0] r_wb_data;
  logic             r_dbg_full;
  logic [ASIZE-1:0] r_dbg_addr;
  logic [DSIZE-1:0] r_dbg_data;
  logic [AGEW-1:0]  r_age;
  logic [15:0]      r_wb_count;

  logic             w_pipe_req;
  logic             w_dbg_req;
  logic             w_force_dbg;
  logic             w_grant_pipe;
  logic             w_grant_dbg;
  logic             w_dbg_accept;
  logic [DSIZE-1:0] w_mem_result;

  always_comb begin
    w_mem_result = mem_alu;
    case (mem_wb_sel)
      2'b01:   w_mem_result = mem_rdata;
      2'b10:   w_mem_result = mem_link;
      default: w_mem_result = mem_alu;
    endcase
  end

  // wb_done marks an entry already written while the stage is held by a stall
  assign w_pipe_req   = r_wb_valid & ~r_wb_done;
  assign w_dbg_req    = r_dbg_full;
  assign w_force_dbg  = w_dbg_req & (r_age == AGE_MAX);
  assign w_grant_dbg  = w_force_dbg | (w_dbg_req & ~w_pipe_req);
  assign w_grant_pipe = w_pipe_req & ~w_force_dbg;
  assign w_dbg_accept = dbg_valid & ~r_dbg_full;

  always_comb begin
    wen   = 1'b0;
    waddr = '0;
    wdata = '0;
    if (w_grant_dbg) begin
      wen   = 1'b1;
      waddr = r_dbg_addr;
      wdata = r_dbg_data;
    end else if (w_grant_pipe) begin
      wen   = 1'b1;
      waddr = r_wb_addr;
      wdata = r_wb_data;
    end
  end

  assign stall_req = w_force_dbg & w_pipe_req;
  assign dbg_ready = ~r_dbg_full;
  assign wb_count  = r_wb_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid <= 1'b0;
      r_wb_done  <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else if (flush) begin
      r_wb_valid <= 1'b0;
      r_wb_done  <= 1'b0;
    end else if (!stall) begin
      r_wb_valid <= mem_wen & (mem_waddr != '0);
      r_wb_addr  <= mem_waddr;
      r_wb_data  <= w_mem_result;
      r_wb_done  <= 1'b0;
    end else if (w_grant_pipe) begin
      r_wb_done  <= 1'b1;
    end
  end

  // A drain and a refill never coincide: accept needs the buffer empty, grant needs it full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dbg_full <= 1'b0;
      r_dbg_addr <= '0;
      r_dbg_data <= '0;
      r_age      <= '0;
    end else if (w_grant_dbg) begin
      r_dbg_full <= 1'b0;
      r_age      <= '0;
    end else if (w_dbg_accept && (dbg_addr != '0)) begin
      r_dbg_full <= 1'b1;
      r_dbg_addr <= dbg_addr;
      r_dbg_data <= dbg_data;
      r_age      <= '0;
    end else if (w_dbg_req && (r_age != AGE_MAX)) begin
      r_age      <= r_age + AGEW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_count <= '0;
    end else if (w_grant_pipe && (r_wb_count != 16'hFFFF)) begin
      r_wb_count <= r_wb_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_write_port.sv
// Scenario bench for wb_write_port: expected writes are queued at stimulus time
// and popped by a port monitor; each scenario task also checks timing inline.
module tb_wb_write_port;
  localparam int DSIZE = 16;
  localparam int ASIZE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             tb_stall;
  logic             stall;
  logic             flush;
  logic             mem_wen;
  logic [ASIZE-1:0] mem_waddr;
  logic [1:0]       mem_wb_sel;
  logic [DSIZE-1:0] mem_alu;
  logic [DSIZE-1:0] mem_rdata;
  logic [DSIZE-1:0] mem_link;
  logic             dbg_valid;
  logic [ASIZE-1:0] dbg_addr;
  logic [DSIZE-1:0] dbg_data;
  logic             dbg_ready;
  logic             wen;
  logic [ASIZE-1:0] waddr;
  logic [DSIZE-1:0] wdata;
  logic             stall_req;
  logic [15:0]      wb_count;

  typedef struct packed {
    logic [ASIZE-1:0] a;
    logic [DSIZE-1:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = '0;

  // the pipeline honours stall_req, as the core does
  assign stall = tb_stall | stall_req;

  always #5 clk = ~clk;

  wb_write_port #(.DSIZE(DSIZE), .ASIZE(ASIZE), .DBG_MAXWAIT(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wb_sel(mem_wb_sel),
    .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_link(mem_link),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_ready(dbg_ready), .wen(wen), .waddr(waddr), .wdata(wdata),
    .stall_req(stall_req), .wb_count(wb_count)
  );

  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b1 && wen === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: write addr=%0d data=%h, no write expected", waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if ({waddr, wdata} !== e) begin
          n_bad++;
          $display("FAIL sb_write: got addr=%0d data=%h, want addr=%0d data=%h", waddr, wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic drive_idle();
    tb_stall = 1'b0; flush = 1'b0; mem_wen = 1'b0; mem_waddr = '0; mem_wb_sel = 2'b00;
    mem_alu = '0; mem_rdata = '0; mem_link = '0;
    dbg_valid = 1'b0; dbg_addr = '0; dbg_data = '0;
  endtask

  task automatic drive_pipe(input logic [ASIZE-1:0] a, input logic [1:0] sel, input logic [DSIZE-1:0] v);
    mem_wen = 1'b1; mem_waddr = a; mem_wb_sel = sel;
    mem_alu = 16'h1111; mem_rdata = 16'h2222; mem_link = 16'h3333;
    case (sel)
      2'b01:   mem_rdata = v;
      2'b10:   mem_link  = v;
      default: mem_alu   = v;
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL rst_wen: got %b want 0", wen); end
    n_cmp++; if (waddr !== '0) begin n_bad++; $display("FAIL rst_waddr: got %0d want 0", waddr); end
    n_cmp++; if (wdata !== '0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", wdata); end
    n_cmp++; if (dbg_ready !== 1'b1) begin n_bad++; $display("FAIL rst_dbg_ready: got %b want 1", dbg_ready); end
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL rst_stall_req: got %b want 0", stall_req); end
    n_cmp++; if (wb_count !== 16'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", wb_count); end
    rst = 1'b1;
    cyc();
    n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL rst_release_wen: got %b want 0", wen); end
  endtask

  task automatic test_alu();
    drive_pipe(4'd3, 2'b00, 16'h1234);
    exp_q.push_back('{a: 4'd3, d: 16'h1234}); exp_cnt++;
    cyc();
    drive_idle();
    n_cmp++; if (wen !== 1'b1) begin n_bad++; $display("FAIL alu_wen: got %b want 1", wen); end
    n_cmp++; if (waddr !== 4'd3) begin n_bad++; $display("FAIL alu_waddr: got %0d want 3", waddr); end
    n_cmp++; if (wdata !== 16'h1234) begin n_bad++; $display("FAIL alu_wdata: got %h want 1234", wdata); end
    cyc();
    n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL alu_idle_wen: got %b want 0", wen); end
    n_cmp++; if (wb_count !== exp_cnt) begin n_bad++; $display("FAIL alu_count: got %0d want %0d", wb_count, exp_cnt); end
  endtask

  task automatic test_sel();
    logic [1:0]       sels [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [ASIZE-1:0] addrs[4] = '{4'd4, 4'd5, 4'd6, 4'd0};
    logic [DSIZE-1:0] vals [4] = '{16'hBEEF, 16'h0040, 16'h7777, 16'hDEAD};
    for (int i = 0; i < 4; i++) begin
      drive_pipe(addrs[i], sels[i], vals[i]);
      if (addrs[i] != '0) begin
        exp_q.push_back('{a: addrs[i], d: vals[i]}); exp_cnt++;
      end
      cyc();
      n_cmp++;
      if (wen !== (addrs[i] != '0)) begin n_bad++; $display("FAIL sel_wen_%0d: got %b want %b", i, wen, addrs[i] != '0); end
      if (i < 3) begin
        n_cmp++;
        if (wdata !== vals[i]) begin n_bad++; $display("FAIL sel_wdata_%0d: got %h want %h", i, wdata, vals[i]); end
      end
    end
    drive_idle();
    cyc();
    n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL sel_r0_wen: got %b want 0", wen); end
    n_cmp++; if (wb_count !== exp_cnt) begin n_bad++; $display("FAIL sel_count: got %0d want %0d", wb_count, exp_cnt); end
  endtask

  task automatic test_stall();
    drive_pipe(4'd5, 2'b00, 16'h5555);
    exp_q.push_back('{a: 4'd5, d: 16'h5555}); exp_cnt++;
    cyc();
    n_cmp++; if (wen !== 1'b1 || waddr !== 4'd5) begin n_bad++; $display("FAIL stall_first: got wen=%b addr=%0d want 1/5", wen, waddr); end
    tb_stall = 1'b1;
    drive_pipe(4'd9, 2'b00, 16'h9999);
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL stall_hold_%0d: got wen=%b want 0", i, wen); end
    end
    n_cmp++; if (wb_count !== exp_cnt) begin n_bad++; $display("FAIL stall_count: got %0d want %0d", wb_count, exp_cnt); end
    flush = 1'b1;
    drive_pipe(4'd7, 2'b00, 16'h7777);
    cyc();
    n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL flush_stall_wen: got %b want 0", wen); end
    tb_stall = 1'b0;
    cyc();
    n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL flush_capture_wen: got %b want 0", wen); end
    drive_idle();
    cyc();
    n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL flush_after_wen: got %b want 0", wen); end
  endtask

  task automatic test_debug();
    n_cmp++; if (dbg_ready !== 1'b1) begin n_bad++; $display("FAIL dbg_ready_idle: got %b want 1", dbg_ready); end
    dbg_valid = 1'b1; dbg_addr = 4'd7; dbg_data = 16'hA5A5;
    exp_q.push_back('{a: 4'd7, d: 16'hA5A5});
    cyc();
    dbg_valid = 1'b0;
    n_cmp++; if (dbg_ready !== 1'b0) begin n_bad++; $display("FAIL dbg_ready_full: got %b want 0", dbg_ready); end
    n_cmp++; if (wen !== 1'b1 || waddr !== 4'd7) begin n_bad++; $display("FAIL dbg_write: got wen=%b addr=%0d want 1/7", wen, waddr); end
    cyc();
    n_cmp++; if (dbg_ready !== 1'b1) begin n_bad++; $display("FAIL dbg_ready_drained: got %b want 1", dbg_ready); end
    n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL dbg_done_wen: got %b want 0", wen); end
    dbg_valid = 1'b1; dbg_addr = 4'd0; dbg_data = 16'h1111;
    cyc();
    dbg_valid = 1'b0;
    n_cmp++; if (dbg_ready !== 1'b1) begin n_bad++; $display("FAIL dbg_r0_ready: got %b want 1", dbg_ready); end
    n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL dbg_r0_wen: got %b want 0", wen); end
    cyc();
    n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL dbg_r0_later_wen: got %b want 0", wen); end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    for (int k = 0; k <= 8; k++) begin
      if (k >= 1) begin
        n_cmp++; if (wen !== 1'b1) begin n_bad++; $display("FAIL b2b_wen_%0d: got %b want 1", k, wen); end
        n_cmp++; if (stall_req !== (k == 5)) begin n_bad++; $display("FAIL b2b_stall_req_%0d: got %b want %b", k, stall_req, k == 5); end
      end
      if (k == 1) begin
        dbg_valid = 1'b0;
        n_cmp++; if (dbg_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_dbg_ready_wait: got %b want 0", dbg_ready); end
      end
      if (k == 6) begin
        n_cmp++; if (dbg_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_dbg_ready_after: got %b want 1", dbg_ready); end
      end
      if (k == 0) begin
        dbg_valid = 1'b1; dbg_addr = 4'd9; dbg_data = 16'hD00D;
      end
      if (k == 4) exp_q.push_back('{a: 4'd9, d: 16'hD00D});
      if (k <= 4 || k == 6 || k == 7) begin
        drive_pipe(ASIZE'(idx + 1), 2'b00, 16'hC000 + DSIZE'(idx));
        exp_q.push_back('{a: ASIZE'(idx + 1), d: 16'hC000 + DSIZE'(idx)}); exp_cnt++;
        idx++;
      end else if (k == 5) begin
        drive_pipe(4'd15, 2'b00, 16'hFFFF);
      end else begin
        mem_wen = 1'b0;
      end
      cyc();
    end
    drive_idle();
    n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL b2b_end_wen: got %b want 0", wen); end
    n_cmp++; if (wb_count !== exp_cnt) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", wb_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    drive_pipe(4'd2, 2'b00, 16'h2222);
    exp_q.push_back('{a: 4'd2, d: 16'h2222}); exp_cnt++;
    dbg_valid = 1'b1; dbg_addr = 4'd10; dbg_data = 16'hABCD;
    cyc();
    dbg_valid = 1'b0;
    drive_pipe(4'd3, 2'b00, 16'h3333);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    exp_cnt = '0;
    drive_idle();
    n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL midrst_wen: got %b want 0", wen); end
    n_cmp++; if (dbg_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_dbg_ready: got %b want 1", dbg_ready); end
    n_cmp++; if (wb_count !== 16'd0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", wb_count); end
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL midrst_stall_req: got %b want 0", stall_req); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL midrst_release_wen_%0d: got %b want 0", i, wen); end
    end
    n_cmp++; if (dbg_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_release_ready: got %b want 1", dbg_ready); end
    n_cmp++; if (wb_count !== exp_cnt) begin n_bad++; $display("FAIL midrst_release_count: got %0d want %0d", wb_count, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_sel();
    test_stall();
    test_debug();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d writes still expected, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_write_port.md
Name: wb_write_port

Overview:
- Writeback-side driver of the register file write port (wen/waddr/wdata) in the pipelined MIPS core.
- Holds the MEM/WB pipeline register and selects the result (ALU, load data, link).
- Suppresses writes to r0.
- Arbitrates the single write port between the pipeline and a debug/loader port that uses a valid/ready handshake, with starvation protection.
- Its wen/waddr/wdata also feed the regfile's write-through bypass.

Parameters:
DSIZE, 16, data width (matches `DSIZE)
ASIZE, 4, register address width (matches `ASIZE)
DBG_MAXWAIT, 4, cycles a buffered debug write may wait before it takes priority

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-low reset
stall  in  1  hold MEM/WB register (global pipeline stall, includes stall_req fed back)
flush  in  1  load a bubble into MEM/WB
mem_wen  in  1  instruction in MEM writes a register
mem_waddr  in  ASIZE  destination register
mem_wb_sel  in  2  00 ALU, 01 load data, 10 link, 11 ALU
mem_alu  in  DSIZE  ALU result
mem_rdata  in  DSIZE  data memory read data
mem_link  in  DSIZE  return address
dbg_valid  in  1  debug write request
dbg_addr  in  ASIZE  debug destination
dbg_data  in  DSIZE  debug data
dbg_ready  out  1  debug buffer empty, request accepted when dbg_valid&dbg_ready
wen  out  1  regfile write enable
waddr  out  ASIZE  regfile write address
wdata  out  DSIZE  regfile write data
stall_req  out  1  pipeline write denied this cycle, upstream must stall
wb_count  out  16  committed pipeline writes, saturating

Behaviour:
- Reset (rst=0, async): wb_valid=0, wb_done=0, dbg_full=0, age=0, wb_count=0. Outputs: wen=0, waddr=0, wdata=0, dbg_ready=1, stall_req=0.
- MEM/WB register update on posedge; flush has priority over stall.
  - flush=1: wb_valid<=0, wb_done<=0.
  - stall=0: wb_valid<=mem_wen & (mem_waddr!=0). wb_addr<=mem_waddr. wb_data<=mux(mem_wb_sel) computed at capture. wb_done<=0.
  - stall=1: hold all fields. wb_done<=1 if the pipe write was granted this cycle.
- Latency: MEM inputs appear on the write port exactly 1 cycle after capture.
- Requests:
  - pipe_req = wb_valid & ~wb_done. Each pipeline result is written exactly once, even across multi-cycle stalls.
  - dbg_req = dbg_full.
- Debug buffer (1 entry):
  - dbg_ready = ~dbg_full.
  - On accept with dbg_addr!=0: dbg_full<=1, address and data captured, age<=0.
  - On accept with dbg_addr==0: the handshake completes and the request is discarded.
  - The buffer cannot be refilled in the same cycle it drains. dbg_ready rises the cycle after the grant.
- Arbitration (combinational from registered state):
  - dbg_req & age==DBG_MAXWAIT: debug granted. stall_req = pipe_req.
  - else pipe_req: pipeline granted.
  - else dbg_req: debug granted.
  - else wen=0, waddr=0, wdata=0.
- Grant effects:
  - wen=1; waddr/wdata come from the granted source.
  - Debug grant clears dbg_full and age.
  - While dbg_req is not granted, age increments, saturating at DBG_MAXWAIT.
- stall_req is only asserted on a forced debug grant. The held pipe entry is written in the next cycle; it is not lost.
- wb_count increments by 1 per pipeline grant and saturates at 16'hFFFF.
- A mid-operation reset discards any pending pipe or debug write. There is no write on the reset-release edge.

Test Plan:
- Reset, then mem_wen=1, waddr=3, sel=00, alu=16'h1234 -> next cycle wen=1, waddr=3, wdata=16'h1234, wb_count=1.
- sel=01 with rdata=16'hBEEF; sel=10 with link=16'h0040; mem_waddr=0 with mem_wen=1 -> wdata=BEEF, then 0040, then wen=0 for r0. wb_count counts 2.
- Capture write to r5, then hold stall=1 for 3 cycles -> wen=1 only in the first cycle; wb_count +1; flush during stall -> wb_valid cleared.
- Idle pipe; dbg_valid with addr=7, data=16'hA5A5 -> accepted (dbg_ready=0 next cycle), write on the following cycle, dbg_ready=1 after. dbg_addr=0 -> accepted, no write.
- Continuous pipe writes plus one debug request -> debug waits 4 cycles, then on the 5th has wen with dbg data and stall_req=1. The held pipe write appears in the next cycle.
- Assert rst low mid-debug-wait with an entry pending -> immediately wen=0, dbg_ready=1, wb_count=0. No write after release.
